// File: rtl/rom_arb_pkg.sv
// Shared widths and state/requester encodings for the ROM read arbiter.
package rom_arb_pkg;

  localparam int ADDR_WIDTH = 2;
  localparam int DATA_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } state_t;

  typedef enum logic {
    REQ_A,
    REQ_B
  } req_id_t;

endpackage

// File: rtl/RAM_ROM.sv
// Combinational 4x4 lookup ROM shared by the two requesters of rom_read_arbiter.
module RAM_ROM
  import rom_arb_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] Addr,
  output logic [DATA_WIDTH-1:0] Dout
);

  always_comb begin
    case (Addr)
      2'd0:    Dout = 4'h4;
      2'd1:    Dout = 4'hC;
      2'd2:    Dout = 4'h6;
      default: Dout = 4'h7;
    endcase
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter giving requesters A and B turns at the shared ROM,
// with a req/ack handshake and registered read data.
module rom_read_arbiter
  import rom_arb_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  req_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  ack_a,
  output logic                  ack_b,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy
);

  state_t                  state, next_state;
  req_id_t                 gnt_q, last_grant, winner;
  logic [ADDR_WIDTH-1:0]   addr_q, winner_addr;
  logic [DATA_WIDTH-1:0]   rom_dout;

  RAM_ROM u_rom (
    .Addr (addr_q),
    .Dout (rom_dout)
  );

  // NOTE: every output of this block is assigned a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    winner     = REQ_A;
    case (state)
      IDLE: begin
        if (req_a && req_b) begin
          winner = (last_grant == REQ_A) ? REQ_B : REQ_A;
        end else if (req_b) begin
          winner = REQ_B;
        end
        if (req_a || req_b) next_state = READ;
      end
      READ:    next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign winner_addr = (winner == REQ_A) ? addr_a : addr_b;
  assign busy        = (state == READ) || (state == RESP);

  // last_grant resets to B so that A wins the first tie after reset.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      gnt_q      <= REQ_A;
      last_grant <= REQ_B;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      rdata      <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req_a || req_b) begin
            addr_q <= winner_addr;
            gnt_q  <= winner;
          end
        end
        READ: begin
          rdata      <= rom_dout;
          ack_a      <= (gnt_q == REQ_A);
          ack_b      <= (gnt_q == REQ_B);
          last_grant <= gnt_q;
        end
        RESP: begin
          ack_a <= 1'b0;
          ack_b <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
